multibank_column_buffer: RTL
============================

// Module: multibank_column_buffer
// PURPOSE
//  Parametrised N-bank column buffer for the feature-adder datapath: the
//  producer fills one bank while the consumer drains another. Banks rotate in a
//  circular queue under a commit/release handshake.
//  Generalises the fixed two-bank dual-port column buffer:
//   - bank count is a parameter;
//   - bank swap is owned in hardware, not by external enables;
//   - per-lane write masking;
//   - read-valid tracking.
// PARAMETERS
//  dataWidth  32    bits per lane (one feature element)
//  pvadd      128   lanes per word (feature-adder parallelism)
//  k          1024  words per bank (block size); addressWidth = $clog2(k)
//  NBUF       2     number of banks, >=2 (need not be a power of two)
//  READ_LAT   2     read latency in cycles, fixed at 2
// PORTS
//  clk            in   1                 single clock; all logic on posedge
//  rst            in   1                 asynchronous, active-high reset
//  wr_valid       in   1                 write request
//  wr_ready       out  1                 a fill bank is available (count < NBUF)
//  wr_addr        in   addressWidth      word address within the fill bank
//  wr_data        in   dataWidth*pvadd   write word; lane i = bits [i*dataWidth +: dataWidth]
//  wr_mask        in   pvadd             per-lane write enable
//  wr_last        in   1                 commit the fill bank after this write
//  rd_valid       in   1                 read request
//  rd_ready       out  1                 a full bank is available (count > 0)
//  rd_addr        in   addressWidth      word address within the drain bank
//  rd_data        out  dataWidth*pvadd   read word, READ_LAT cycles after accept
//  rd_data_valid  out  1                 qualifies rd_data
//  rd_release     in   1                 consumer finished the drain bank
//  full_count     out  $clog2(NBUF+1)    number of committed, unreleased banks
//  wr_bank        out  $clog2(NBUF)      index of the current fill bank
//  rd_bank        out  $clog2(NBUF)      index of the current drain bank
// BEHAVIOUR
//  Reset state (async, rst=1): wr_bank=0, rd_bank=0, full_count=0, rd_data=0,
//   rd_data_valid=0, read pipeline flushed. RAM contents are not reset.
//   rst asserted mid-operation drops in-flight reads: no rd_data_valid follows.
//  Bank state: full_count counts committed banks.
//   - wr_ready = (full_count != NBUF), combinational.
//   - rd_ready = (full_count != 0), combinational.
//  Write accept = wr_valid & wr_ready.
//   - Lane i of bank wr_bank, word wr_addr, is written iff wr_mask[i].
//   - Unmasked lanes keep their old value.
//   - wr_valid with wr_ready=0 is ignored; no write, no state change.
//  Commit = accept & wr_last.
//   - The write still happens.
//   - wr_bank advances (NBUF-1 wraps to 0) and full_count increments.
//   - A single-write fill is legal.
//  Read accept = rd_valid & rd_ready.
//   - RAM word (rd_bank, rd_addr) is sampled at the accept edge (stage 1).
//   - It is registered again (stage 2).
//   - rd_data and rd_data_valid=1 appear exactly 2 cycles after accept.
//   - Fully pipelined: one read per cycle.
//   - rd_data holds its last value when rd_data_valid=0.
//   - rd_valid with rd_ready=0 is ignored.
//  Release = rd_release & rd_ready.
//   - rd_bank advances with wrap and full_count decrements.
//   - rd_release with rd_ready=0 is ignored.
//   - A read accepted in the same cycle as release uses the old rd_bank.
//   - Reads in flight complete with pre-release data, even if the writer
//     overwrites the bank on the next cycle (data was captured at stage 1).
//  Simultaneous commit and release: full_count unchanged; both pointers advance.
//  Reading and writing the same bank is impossible by construction: the drain
//   bank is always committed and the fill bank never is. No collision logic.
//  Read and write may be accepted in the same cycle to different banks.
// TESTING
//  1 Reset: drive rst=1 mid-stream, then release -> full_count=0, wr_ready=1,
//    rd_ready=0, rd_data_valid=0, no stale valids after reset.
//  2 Fill/drain, NBUF=2: write addr 0..3 with data=addr (all lanes), wr_last on
//    addr 3 -> full_count=1; read 0..3 back-to-back -> data 0..3 on cycles +2..+5.
//  3 Backpressure, NBUF=2: commit 2 banks -> wr_ready=0 and the next write is
//    dropped; release -> wr_ready=1 next cycle, wr_bank=0.
//  4 Masking: write 0xFFFFFFFF to all lanes, then wr_mask=...0101 with data 0 ->
//    even lanes read 0, odd lanes read 0xFFFFFFFF.
//  5 Same-cycle commit+release with full_count=1 -> full_count stays 1;
//    rd_bank and wr_bank both advance.
//  6 Wrap, NBUF=3: 7 commit/release cycles -> pointers wrap 2->0; a read issued
//    alongside release returns the old bank's data.

Source files
------------

// File: rtl/multibank_column_buffer.sv
// multibank_column_buffer
//   N-bank column buffer for the feature-adder datapath. The producer fills
//   bank wr_bank while the consumer drains bank rd_bank; banks rotate through
//   a circular queue driven by commit (wr_last) and release (rd_release).
//   full_count tracks committed, unreleased banks. The drain bank is always
//   committed and the fill bank never is, so the two never alias and no
//   read/write collision logic is needed.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   wr_valid/ready  write handshake; wr_ready while a free bank exists
//   wr_addr/data    word address and data within the fill bank
//   wr_mask         per-lane write enable (lane i = bits [i*dataWidth +: dataWidth])
//   wr_last         commit the fill bank after this write
//   rd_valid/ready  read handshake; rd_ready while a committed bank exists
//   rd_addr         word address within the drain bank
//   rd_data/valid   read word, two cycles after the read is accepted
//   rd_release      consumer is done with the drain bank
//   full_count      committed, unreleased banks
//   wr_bank/rd_bank current fill / drain bank index
module multibank_column_buffer #(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int k         = 1024,
    parameter int NBUF      = 2,
    parameter int READ_LAT  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(k)-1:0]         wr_addr,
    input  logic [dataWidth*pvadd-1:0]   wr_data,
    input  logic [pvadd-1:0]             wr_mask,
    input  logic                         wr_last,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [$clog2(k)-1:0]         rd_addr,
    output logic [dataWidth*pvadd-1:0]   rd_data,
    output logic                         rd_data_valid,
    input  logic                         rd_release,
    output logic [$clog2(NBUF+1)-1:0]    full_count,
    output logic [$clog2(NBUF)-1:0]      wr_bank,
    output logic [$clog2(NBUF)-1:0]      rd_bank
);

    localparam int wordWidth  = dataWidth * pvadd;
    localparam int bankWidth  = $clog2(NBUF);
    localparam int countWidth = $clog2(NBUF + 1);
    localparam logic [bankWidth-1:0]  lastBank  = bankWidth'(NBUF - 1);
    localparam logic [countWidth-1:0] bankCount = countWidth'(NBUF);

    logic [wordWidth-1:0] mem [NBUF][k];
    logic [wordWidth-1:0] stage1Data;
    logic [READ_LAT-1:0]  validPipe;

    logic wrAccept;
    logic commit;
    logic rdAccept;
    logic bankRelease;

    // NBUF need not be a power of two, so wrap explicitly.
    function automatic logic [bankWidth-1:0] nextBank(input logic [bankWidth-1:0] b);
        return (b == lastBank) ? '0 : b + 1'b1;
    endfunction

    assign wr_ready    = (full_count != bankCount);
    assign rd_ready    = (full_count != '0);
    assign wrAccept    = wr_valid & wr_ready;
    assign commit      = wrAccept & wr_last;
    assign rdAccept    = rd_valid & rd_ready;
    assign bankRelease = rd_release & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank    <= '0;
            rd_bank    <= '0;
            full_count <= '0;
        end else begin
            if (commit) begin
                wr_bank <= nextBank(wr_bank);
            end
            if (bankRelease) begin
                rd_bank <= nextBank(rd_bank);
            end
            // Simultaneous commit and release leaves the count unchanged.
            if (commit && !bankRelease) begin
                full_count <= full_count + 1'b1;
            end else if (bankRelease && !commit) begin
                full_count <= full_count - 1'b1;
            end
        end
    end

    // Storage is not reset. Stage 1 captures the word at the accept edge, so a
    // read issued alongside a release still returns the pre-release contents
    // even if the writer reuses that bank right afterwards.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            for (int i = 0; i < pvadd; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_bank][wr_addr][i*dataWidth +: dataWidth] <= wr_data[i*dataWidth +: dataWidth];
                end
            end
        end
        if (rdAccept) begin
            stage1Data <= mem[rd_bank][rd_addr];
        end
    end

    // Valid pipeline is reset so that reads in flight at reset are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe <= '0;
            rd_data   <= '0;
        end else begin
            validPipe <= {validPipe[READ_LAT-2:0], rdAccept};
            if (validPipe[0]) begin
                rd_data <= stage1Data;
            end
        end
    end

    assign rd_data_valid = validPipe[READ_LAT-1];

endmodule
